// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data memory between the CPU load/store
//   path and a periodic display scanner that reads two bytes into display_word.
// Latency: CPU grant is combinational; load data and cpu_valid appear one cycle after the grant.
// Backpressure: the CPU holds cpu_req until cpu_gnt. A scan owns the port for two cycles and is
//   never interrupted. The CPU wins arbitration until a pending scan has waited STARVE_LIMIT grants.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU access request (held until granted)
//   cpu_gnt                    access granted this cycle (combinational)
//   cpu_valid, cpu_rdata       load data pulse; the data is held until the next load
//   mem_we/addr/wdata, mem_rdata   data_memory port (synchronous read)
//   display_word               {hi, lo} display bytes, updated atomically
//   scan_busy                  scanner owns the memory port this cycle
//   stall_count                cycles with cpu_req=1 and cpu_gnt=0 (only with ARB_STALL_COUNT_EN)
module data_mem_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int REFRESH_CYCLES = 1000,
    parameter int STARVE_LIMIT   = 4,
    parameter logic [ADDR_W-1:0] DISP_ADDR_LO = ADDR_W'(254),
    parameter logic [ADDR_W-1:0] DISP_ADDR_HI = ADDR_W'(255)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       display_word,
    output logic              scan_busy
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SCAN_LO, SCAN_HI, SCAN_CAP} state_e;

    state_e            state_q;
    logic [RW-1:0]     refresh_cnt_q;
    logic              scan_pending_q;
    logic [SW-1:0]     starve_cnt_q;
    logic [DATA_W-1:0] lo_hold_q;
    logic [DATA_W-1:0] rdata_hold_q;
    logic              load_pend_q;
    logic [15:0]       display_word_q;

    logic arb_state;
    logic starved;
    logic scan_start;
    logic grant;
    logic refresh_tc;

    // Arbitration only happens when the scanner does not own the port.
    assign arb_state  = (state_q == IDLE) || (state_q == SCAN_CAP);
    assign starved    = (starve_cnt_q == STARVE_MAX);
    assign scan_start = arb_state && scan_pending_q && (!cpu_req || starved);
    assign grant      = arb_state && cpu_req && !scan_start;
    assign refresh_tc = (refresh_cnt_q == REFRESH_LAST);

    assign cpu_gnt      = grant;
    assign cpu_valid    = load_pend_q;
    // Load data is presented straight from the memory in the completion
    // cycle, then held from the capture register until the next load.
    assign cpu_rdata    = load_pend_q ? mem_rdata : rdata_hold_q;
    assign display_word = display_word_q;
    assign scan_busy    = (state_q == SCAN_LO) || (state_q == SCAN_HI);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            SCAN_LO: mem_addr = DISP_ADDR_LO;
            SCAN_HI: mem_addr = DISP_ADDR_HI;
            default: begin
                if (grant) begin
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            refresh_cnt_q  <= '0;
            scan_pending_q <= 1'b0;
            starve_cnt_q   <= '0;
            lo_hold_q      <= '0;
            rdata_hold_q   <= '0;
            load_pend_q    <= 1'b0;
            display_word_q <= '0;
        end else begin
            refresh_cnt_q <= refresh_tc ? '0 : refresh_cnt_q + RW'(1);

            // A terminal count while a scan is already pending is dropped;
            // the one consumed this cycle also absorbs a coincident count.
            if (scan_start) begin
                scan_pending_q <= 1'b0;
            end else if (refresh_tc) begin
                scan_pending_q <= 1'b1;
            end

            load_pend_q <= grant && !cpu_we;
            if (load_pend_q) begin
                rdata_hold_q <= mem_rdata;
            end

            case (state_q)
                SCAN_LO: state_q <= SCAN_HI;
                SCAN_HI: begin
                    lo_hold_q <= mem_rdata;
                    state_q   <= SCAN_CAP;
                end
                default: begin
                    // The high byte returns in SCAN_CAP; both bytes land together.
                    if (state_q == SCAN_CAP) begin
                        display_word_q <= {mem_rdata, lo_hold_q};
                    end
                    if (scan_start) begin
                        state_q      <= SCAN_LO;
                        starve_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                        if (grant && scan_pending_q && !starved) begin
                            starve_cnt_q <= starve_cnt_q + SW'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;
    assign stall_count = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (cpu_req && !grant && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with REFRESH_CYCLES=8, STARVE_LIMIT=4.
// Cycle n is the interval after the n-th rising edge following reset release.
// Inputs are driven just after an edge, outputs sampled 1ns later.
module tb_data_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_valid;
    logic [7:0]  cpu_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] display_word;
    logic        scan_busy;
`ifdef ARB_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [7:0]  mem [256];
    logic [11:0] busy_mask;
    logic [7:0]  gnt_mask;
    logic [7:0]  busy_mask8;

    data_mem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .REFRESH_CYCLES(8), .STARVE_LIMIT(4),
        .DISP_ADDR_LO(8'd254), .DISP_ADDR_HI(8'd255)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .display_word(display_word), .scan_busy(scan_busy)
`ifdef ARB_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read single-port memory model.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic drive(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[254] = 8'h34;
        mem[255] = 8'h12;
        mem_rdata = 8'h00;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_display", 32'(display_word), 32'h0000);
        check("rst_busy_gnt_valid", {29'd0, scan_busy, cpu_gnt, cpu_valid}, 32'h0);
        check("rst_mem_port", {15'd0, mem_we, mem_addr, mem_wdata}, 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        cyc = 0;

        // Idle CPU: first scan occupies cycles 9-10, display lands at edge 12.
        busy_mask = '0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            busy_mask[cyc-1] = scan_busy;
        end
        check("scan1_display_before", 32'(display_word), 32'h0000);
        tick();
        busy_mask[cyc-1] = scan_busy;
        check("scan1_busy_pattern", 32'(busy_mask), 32'h300);
        check("scan1_display", 32'(display_word), 32'h1234);

        // Store A5 to address 3, then load it back.
        tick();
        drive(1'b1, 1'b1, 8'd3, 8'hA5);
        #1;
        check("store_gnt", 32'(cpu_gnt), 32'h1);
        check("store_mem_port", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b1, 8'd3, 8'hA5});
        tick();
        drive(1'b1, 1'b0, 8'd3, 8'h00);
        #1;
        check("load_gnt_we", {30'd0, cpu_gnt, mem_we}, 32'h2);
        check("store_no_valid", 32'(cpu_valid), 32'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("load_valid", 32'(cpu_valid), 32'h1);
        check("load_rdata", 32'(cpu_rdata), 32'hA5);
        check("idle_mem_addr", {23'd0, mem_we, mem_addr}, 32'h0);

        // Continuous CPU loads while a scan is pending (cycles 16-23).
        tick();
        drive(1'b1, 1'b0, 8'd3, 8'h00);
        #1;
        check("valid_pulse_end", 32'(cpu_valid), 32'h0);
        check("rdata_held", 32'(cpu_rdata), 32'hA5);
        gnt_mask   = '0;
        busy_mask8 = '0;
        gnt_mask[0]   = cpu_gnt;
        busy_mask8[0] = scan_busy;
        for (int c = 17; c <= 23; c++) begin
            tick();
            #1;
            gnt_mask[cyc-16]   = cpu_gnt;
            busy_mask8[cyc-16] = scan_busy;
            if (cyc == 21) check("starve_scan_lo_addr", 32'(mem_addr), 32'd254);
        end
        check("starve_gnt_pattern", 32'(gnt_mask), 32'h8F);
        check("starve_busy_pattern", 32'(busy_mask8), 32'h60);

        // Scan at cycles 25-26; store 99 to 254 offered during SCAN_HI.
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("scan2_start_gnt", {30'd0, cpu_gnt, scan_busy}, 32'h0);
        tick();
        #1;
        check("scan2_lo", {23'd0, scan_busy, mem_addr}, {23'd0, 1'b1, 8'd254});
        tick();
        drive(1'b1, 1'b1, 8'd254, 8'h99);
        #1;
        check("scan2_hi_defer", {22'd0, cpu_gnt, mem_we, mem_addr}, {22'd0, 2'b00, 8'd255});
        tick();
        #1;
        check("deferred_store", {14'd0, cpu_gnt, mem_we, mem_addr, mem_wdata},
              {14'd0, 2'b11, 8'd254, 8'h99});
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("scan2_old_low", 32'(display_word), 32'h1234);
        run_to(35);
        check("scan3_display_before", 32'(display_word), 32'h1234);
        tick();
        check("scan3_display", 32'(display_word), 32'h1299);

        // Reset during SCAN_HI (cycle 42).
        run_to(42);
        check("pre_reset_scan_hi", {23'd0, scan_busy, mem_addr}, {23'd0, 1'b1, 8'd255});
        reset = 1'b0;
        #1;
        check("midreset_display", 32'(display_word), 32'h0000);
        check("midreset_outputs", {29'd0, scan_busy, cpu_gnt, cpu_valid}, 32'h0);
        check("midreset_mem_port", {15'd0, mem_we, mem_addr, mem_wdata}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc = 0;
        tick();
        check("post_reset_display", 32'(display_word), 32'h0000);
        run_to(8);
        check("post_reset_no_update", {15'd0, scan_busy, display_word}, 32'h0);
        tick();
        check("post_reset_scan_busy", 32'(scan_busy), 32'h1);
        run_to(12);
        check("post_reset_scan_display", 32'(display_word), 32'h1299);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
